// File: rtl/mult_seq_pkg.sv
// mult_seq_pkg: shared state type, phase codes and product width for the
// round-robin multiply-sequence arbiter.
package mult_seq_pkg;

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [1:0] PH_X1 = 2'd0;
    localparam logic [1:0] PH_X3 = 2'd1;
    localparam logic [1:0] PH_X7 = 2'd2;
    localparam logic [1:0] PH_X8 = 2'd3;

    localparam int OUT_W = 11;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick; searches upward from ptr_i+1
// modulo NREQ and returns a one-hot grant plus the winner's index.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 3
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    output logic [NREQ-1:0] grant_o,
    output logic [IDW-1:0]  id_o,
    output logic            any_o
);

    int idx;

    always_comb begin
        grant_o = '0;
        id_o    = '0;
        any_o   = 1'b0;
        idx     = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(ptr_i) + k) % NREQ;
            if (!any_o && req_i[idx]) begin
                grant_o[idx] = 1'b1;
                id_o         = IDW'(idx);
                any_o        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mult_seq_arbiter.sv
// mult_seq_arbiter: shares one x1/x3/x7/x8 product sequencer among NREQ requesters.
// Define MSEL_STATS_EN to build saturating per-requester grant counters.
module mult_seq_arbiter
    import mult_seq_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [8*NREQ-1:0]     req_data,
    output logic [NREQ-1:0]       req_ready,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OUT_W-1:0]      out_data,
    output logic [IDW-1:0]        out_id,
    output logic [1:0]            out_phase,
    output logic                  out_last,
    output logic                  busy,
    output logic [16*NREQ-1:0]    stat_grants
);

    state_t             state_q, state_d;
    logic [IDW-1:0]     ptr_q, ptr_d;
    logic [IDW-1:0]     id_q, id_d;
    logic [7:0]         opnd_q, opnd_d;
    logic [1:0]         phase_q, phase_d;
    logic [OUT_W-1:0]   data_q, prod_d, ext;
    logic [NREQ-1:0]    grant;
    logic [IDW-1:0]     gnt_id;
    logic               any_req, accept, last_acc, arb_en, grant_fire;

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .req_i   (req_valid),
        .ptr_i   (ptr_q),
        .grant_o (grant),
        .id_o    (gnt_id),
        .any_o   (any_req)
    );

    // Arbitration is open in IDLE and in the cycle the final product is taken,
    // which lets back-to-back operations run without a bubble.
    assign accept     = (state_q == RUN) && out_ready;
    assign last_acc   = accept && (phase_q == PH_X8);
    assign arb_en     = (state_q == IDLE) || last_acc;
    assign grant_fire = arb_en && any_req;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= IDW'(NREQ - 1);
            id_q    <= '0;
            opnd_q  <= '0;
            phase_q <= PH_X1;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            opnd_q  <= opnd_d;
            phase_q <= phase_d;
            data_q  <= (state_d == RUN) ? prod_d : '0;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        opnd_d  = opnd_q;
        phase_d = phase_q;
        if (grant_fire) begin
            state_d = RUN;
            ptr_d   = gnt_id;
            id_d    = gnt_id;
            opnd_d  = req_data[gnt_id*8 +: 8];
            phase_d = PH_X1;
        end else if (last_acc) begin
            state_d = IDLE;
            phase_d = PH_X1;
        end else if (accept) begin
            phase_d = phase_q + 2'd1;
        end
        ext    = OUT_W'(opnd_d);
        prod_d = (phase_d == PH_X1) ? ext :
                 (phase_d == PH_X3) ? (ext << 1) + ext :
                 (phase_d == PH_X7) ? (ext << 3) - ext : ext << 3;
    end

    always_comb begin
        out_valid = (state_q == RUN);
        busy      = (state_q == RUN);
        req_ready = arb_en ? grant : '0;
        out_data  = data_q;
        out_id    = id_q;
        out_phase = phase_q;
        out_last  = (state_q == RUN) && (phase_q == PH_X8);
    end

`ifdef MSEL_STATS_EN
    logic [15:0] cnt_q [NREQ];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREQ; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++)
                if (grant_fire && grant[i] && cnt_q[i] != 16'hFFFF) cnt_q[i] <= cnt_q[i] + 16'd1;
        end
    end

    for (genvar g = 0; g < NREQ; g++) begin : g_stat
        assign stat_grants[16*g +: 16] = cnt_q[g];
    end
`else
    assign stat_grants = '0;
`endif

endmodule

// File: tb/tb_mult_seq_arbiter.sv
// tb_mult_seq_arbiter: directed scenarios then random traffic, checked every
// cycle against a transaction-level model of the scheduler.
module tb_mult_seq_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 3;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [8*NREQ-1:0]    req_data;
    logic [NREQ-1:0]      req_ready;
    logic                 out_valid;
    logic                 out_ready;
    logic [10:0]          out_data;
    logic [IDW-1:0]       out_id;
    logic [1:0]           out_phase;
    logic                 out_last;
    logic                 busy;
    logic [16*NREQ-1:0]   stat_grants;

    mult_seq_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_id      (out_id),
        .out_phase   (out_phase),
        .out_last    (out_last),
        .busy        (busy),
        .stat_grants (stat_grants)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    bit m_busy, m_fresh;
    int m_id, m_d, m_ph, m_ptr;
    int m_cnt [NREQ];
    bit pend  [NREQ];
    int pdata [NREQ];
    int mult  [4] = '{1, 3, 7, 8};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy  = 1'b0;
        m_fresh = 1'b1;
        m_ptr   = NREQ - 1;
        m_ph    = 0;
        for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
    endtask

    // One clock: drive pending requests, check everything, advance the model.
    task automatic step(input bit rdy, input bit r);
        int win;
        bit arb;
        @(negedge clk);
        rst       = r;
        out_ready = rdy;
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]        = pend[i];
            req_data[8*i +: 8]  = 8'(pdata[i]);
        end
        #1;
        if (r) begin
            model_reset();
            @(posedge clk);
            return;
        end
        check("out_valid", out_valid, m_busy);
        check("busy", busy, m_busy);
        if (m_busy) begin
            check("out_data", out_data, m_d * mult[m_ph]);
            check("out_id", out_id, m_id);
            check("out_phase", out_phase, m_ph);
            check("out_last", out_last, m_ph == 3);
        end else if (m_fresh) begin
            check("rst_data", out_data, 0);
            check("rst_id", out_id, 0);
            check("rst_phase", out_phase, 0);
            check("rst_last", out_last, 0);
        end
        arb = !m_busy || (rdy && m_ph == 3);
        win = -1;
        if (arb)
            for (int k = 1; k <= NREQ; k++) begin
                int j = (m_ptr + k) % NREQ;
                if (win < 0 && pend[j]) win = j;
            end
        check("req_ready", req_ready, win >= 0 ? (1 << win) : 0);
        if (m_busy && rdy) begin
            m_ph++;
            if (m_ph == 4) m_busy = 1'b0;
        end
        if (win >= 0) begin
            m_busy     = 1'b1;
            m_fresh    = 1'b0;
            m_id       = win;
            m_d        = pdata[win];
            m_ph       = 0;
            m_ptr      = win;
            pend[win]  = 1'b0;
            if (m_cnt[win] < 65535) m_cnt[win]++;
        end
        @(posedge clk);
    endtask

    initial begin
        rst       = 1'b1;
        out_ready = 1'b0;
        req_valid = '0;
        req_data  = '0;
        for (int i = 0; i < NREQ; i++) begin
            pend[i]  = 1'b0;
            pdata[i] = 0;
        end
        model_reset();
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        pend[0] = 1'b1; pdata[0] = 5;
        repeat (6) step(1'b1, 1'b0);
        pend[3] = 1'b1; pdata[3] = 255;
        repeat (6) step(1'b1, 1'b0);
        pend[0] = 1'b1; pdata[0] = 11;
        pend[2] = 1'b1; pdata[2] = 22;
        repeat (10) step(1'b1, 1'b0);
        pend[1] = 1'b1; pdata[1] = 33;
        pend[2] = 1'b1; pdata[2] = 44;
        repeat (10) step(1'b1, 1'b0);
        pend[1] = 1'b1; pdata[1] = 9;
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        repeat (3) step(1'b0, 1'b0);
        repeat (4) step(1'b1, 1'b0);
        pend[1] = 1'b1; pdata[1] = 10;
        repeat (3) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        pend[0] = 1'b1; pdata[0] = 77;
        pend[3] = 1'b1; pdata[3] = 99;
        repeat (10) step(1'b1, 1'b0);
        for (int i = 0; i < NREQ; i++) check("stat_directed", stat_grants[16*i +: 16],
`ifdef MSEL_STATS_EN
            m_cnt[i]
`else
            0
`endif
        );
        repeat (3000) begin
            for (int i = 0; i < NREQ; i++)
                if (!pend[i] && $urandom_range(3) == 0) begin
                    pend[i]  = 1'b1;
                    pdata[i] = ($urandom_range(9) == 0) ? 255 :
                               ($urandom_range(9) == 0) ? 0 : int'($urandom_range(255));
                end
            step($urandom_range(9) < 7, $urandom_range(299) == 0);
        end
        for (int i = 0; i < NREQ; i++) check("stat_final", stat_grants[16*i +: 16],
`ifdef MSEL_STATS_EN
            m_cnt[i]
`else
            0
`endif
        );
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
